// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_reg_arbiter
// Brief    : Round-robin write arbiter for one shared DW-bit register, with
//            bounded lock-based tenure extension.
// Revision : 1.0
// ============================================================================
module shared_reg_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 10,
  parameter int MAXHOLD = 3
) (
  input  logic                      clock_1,
  input  logic                      in0,
  input  logic [NREQ-1:0]           in1,
  input  logic [NREQ*DW-1:0]        in2,
  input  logic [NREQ-1:0]           in3,
  output logic [NREQ-1:0]           out1,
  output logic [DW-1:0]             out2,
  output logic                      out3,
  output logic [$clog2(NREQ)-1:0]   out4
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAXHOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]      state_q,   state_d;
  logic [NREQ-1:0] grant_q,   grant_d;
  logic [IW-1:0]   idx_q,     idx_d;
  logic [IW-1:0]   ptr_q,     ptr_d;
  logic [HW-1:0]   holdcnt_q, holdcnt_d;
  logic [DW-1:0]   reg_q,     reg_d;

  logic [IW-1:0]   w_arb_base;
  logic [IW-1:0]   w_arb_idx;
  logic [IW-1:0]   w_cand;
  logic [NREQ-1:0] w_arb_onehot;
  logic [IW-1:0]   w_next_ptr;
  logic            w_req_g;
  logic            w_lock_g;
  logic [DW-1:0]   w_data_g;
  logic            w_continue;

  // Scan starts at ptr from IDLE, or just past the grantee on release.
  assign w_next_ptr = idx_q + 1'b1;
  assign w_arb_base = (state_q == S_IDLE) ? ptr_q : w_next_ptr;

  // Walk from the far end back toward the base so the closest hit wins.
  always_comb begin
    w_arb_idx = '0;
    w_cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = w_arb_base + IW'(k);
      if (in1[w_cand]) begin
        w_arb_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_arb_onehot            = '0;
    w_arb_onehot[w_arb_idx] = 1'b1;
  end

  assign w_req_g    = in1[idx_q];
  assign w_lock_g   = in3[idx_q];
  assign w_data_g   = in2[idx_q*DW +: DW];
  assign w_continue = w_req_g & w_lock_g & (holdcnt_q < HOLD_MAX);

  always_ff @(posedge clock_1 or posedge in0) begin
    if (in0) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      holdcnt_q <= '0;
      reg_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      holdcnt_q <= holdcnt_d;
      reg_q     <= reg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    holdcnt_d = holdcnt_q;
    reg_d     = reg_q;
    case (state_q)
      S_IDLE: begin
        if (|in1) begin
          idx_d     = w_arb_idx;
          grant_d   = w_arb_onehot;
          holdcnt_d = '0;
          state_d   = S_GRANT;
        end
      end
      S_GRANT, S_HOLD: begin
        if (w_req_g) begin
          reg_d = w_data_g;
        end
        if (w_continue) begin
          holdcnt_d = holdcnt_q + 1'b1;
          state_d   = S_HOLD;
        end else begin
          // Release: back-to-back handover when anyone is still asking.
          ptr_d     = w_next_ptr;
          holdcnt_d = '0;
          if (|in1) begin
            idx_d   = w_arb_idx;
            grant_d = w_arb_onehot;
            state_d = S_GRANT;
          end else begin
            grant_d = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        grant_d   = '0;
        holdcnt_d = '0;
      end
    endcase
  end

  always_comb begin
    out1 = grant_q;
    out2 = reg_q;
    out3 = (state_q != S_IDLE);
    out4 = idx_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_reg_arbiter
// Brief    : Directed vector table plus corner sequences for shared_reg_arbiter.
// Revision : 1.0
// ============================================================================
module tb_shared_reg_arbiter;

  logic        clk;
  logic        in0;
  logic [3:0]  in1;
  logic [39:0] in2;
  logic [3:0]  in3;
  logic [3:0]  out1;
  logic [9:0]  out2;
  logic        out3;
  logic [1:0]  out4;

  int checks = 0;
  int errors = 0;

  shared_reg_arbiter #(.NREQ(4), .DW(10), .MAXHOLD(3)) dut (
    .clock_1 (clk),
    .in0     (in0),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .out1    (out1),
    .out2    (out2),
    .out3    (out3),
    .out4    (out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [39:0] data;
    logic [3:0]  lock;
    logic [3:0]  e_gnt;
    logic [9:0]  e_reg;
    logic        e_busy;
    logic [1:0]  e_idx;
  } vec_t;

  vec_t vq[$];

  function automatic logic [39:0] pk(logic [9:0] a, logic [9:0] b,
                                     logic [9:0] c, logic [9:0] d);
    return {d, c, b, a};
  endfunction

  function automatic vec_t mk(logic rst, logic [3:0] req, logic [39:0] data,
                              logic [3:0] lock, logic [3:0] gnt,
                              logic [9:0] rg, logic busy, logic [1:0] idx);
    vec_t v;
    v.rst = rst; v.req = req; v.data = data; v.lock = lock;
    v.e_gnt = gnt; v.e_reg = rg; v.e_busy = busy; v.e_idx = idx;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [39:0] d1, d2, d3, d4, d5;
    d1 = pk(10'h001, 10'h002, 10'h003, 10'h004);
    d2 = pk(10'h000, 10'h09d, 10'h000, 10'h000);
    d3 = pk(10'h0a0, 10'h0b1, 10'h000, 10'h000);
    d4 = pk(10'h000, 10'h111, 10'h222, 10'h000);
    d5 = pk(10'h000, 10'h3ff, 10'h222, 10'h000);

    // reset, then full contention without lock
    vq.push_back(mk(1, 4'b1111, pk(10'h3a5, 10'h15a, 10'h2c3, 10'h0ff), 4'b1111, 4'b0000, 10'h000, 0, 2'd0));
    vq.push_back(mk(0, 4'b1111, d1, 4'b0000, 4'b0001, 10'h000, 1, 2'd0));
    vq.push_back(mk(0, 4'b1111, d1, 4'b0000, 4'b0010, 10'h001, 1, 2'd1));
    vq.push_back(mk(0, 4'b1111, d1, 4'b0000, 4'b0100, 10'h002, 1, 2'd2));
    vq.push_back(mk(0, 4'b1111, d1, 4'b0000, 4'b1000, 10'h003, 1, 2'd3));
    vq.push_back(mk(0, 4'b1111, d1, 4'b0000, 4'b0001, 10'h004, 1, 2'd0));
    vq.push_back(mk(0, 4'b0000, d1, 4'b0000, 4'b0000, 10'h004, 0, 2'd0));
    // single request: dropped after first grant, then held
    vq.push_back(mk(0, 4'b0010, d2, 4'b0000, 4'b0010, 10'h004, 1, 2'd1));
    vq.push_back(mk(0, 4'b0000, d2, 4'b0000, 4'b0000, 10'h004, 0, 2'd1));
    vq.push_back(mk(0, 4'b0010, d2, 4'b0000, 4'b0010, 10'h004, 1, 2'd1));
    vq.push_back(mk(0, 4'b0010, d2, 4'b0000, 4'b0010, 10'h09d, 1, 2'd1));
    vq.push_back(mk(0, 4'b0000, d2, 4'b0000, 4'b0000, 10'h09d, 0, 2'd1));
    // lock limit: four cycles of requester 0, one of requester 1
    vq.push_back(mk(0, 4'b0011, d3, 4'b0001, 4'b0001, 10'h09d, 1, 2'd0));
    vq.push_back(mk(0, 4'b0011, d3, 4'b0001, 4'b0001, 10'h0a0, 1, 2'd0));
    vq.push_back(mk(0, 4'b0011, d3, 4'b0001, 4'b0001, 10'h0a0, 1, 2'd0));
    vq.push_back(mk(0, 4'b0011, d3, 4'b0001, 4'b0001, 10'h0a0, 1, 2'd0));
    vq.push_back(mk(0, 4'b0011, d3, 4'b0001, 4'b0010, 10'h0a0, 1, 2'd1));
    vq.push_back(mk(0, 4'b0011, d3, 4'b0001, 4'b0001, 10'h0b1, 1, 2'd0));
    vq.push_back(mk(0, 4'b0000, d3, 4'b0001, 4'b0000, 10'h0b1, 0, 2'd0));
    // request drop while holding
    vq.push_back(mk(0, 4'b0110, d4, 4'b0010, 4'b0010, 10'h0b1, 1, 2'd1));
    vq.push_back(mk(0, 4'b0110, d4, 4'b0010, 4'b0010, 10'h111, 1, 2'd1));
    vq.push_back(mk(0, 4'b0100, d5, 4'b0010, 4'b0100, 10'h111, 1, 2'd2));
    vq.push_back(mk(0, 4'b0000, d5, 4'b0010, 4'b0000, 10'h111, 0, 2'd2));

    in0 = 1'b1;
    in1 = '0;
    in2 = '0;
    in3 = '0;
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      in0 = vq[i].rst;
      in1 = vq[i].req;
      in2 = vq[i].data;
      in3 = vq[i].lock;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d gnt", i),  16'(out1), 16'(vq[i].e_gnt));
      check($sformatf("v%0d reg", i),  16'(out2), 16'(vq[i].e_reg));
      check($sformatf("v%0d busy", i), 16'(out3), 16'(vq[i].e_busy));
      check($sformatf("v%0d idx", i),  16'(out4), 16'(vq[i].e_idx));
    end

    // Reset mid-hold: requester 2 reaches HOLD with holdcnt 2 and reg 0x155.
    in1 = 4'b0100;
    in3 = 4'b0100;
    in2 = pk(10'h000, 10'h000, 10'h155, 10'h000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold gnt", 16'(out1), 16'h0004);
    check("hold reg", 16'(out2), 16'h0155);
    #2 in0 = 1'b1;
    #1;
    check("async rst gnt",  16'(out1), 16'h0000);
    check("async rst reg",  16'(out2), 16'h0000);
    check("async rst busy", 16'(out3), 16'h0000);
    check("async rst idx",  16'(out4), 16'h0000);
    in1 = 4'b1100;
    in3 = 4'b0000;
    @(negedge clk);
    in0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post rst gnt",  16'(out1), 16'h0004);
    check("post rst idx",  16'(out4), 16'h0002);
    check("post rst busy", 16'(out3), 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
